// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the fetch queue and the decode stage.
//   ADDR_WIDTH    - default PC width in bits
//   INSTR_WIDTH   - default instruction width in bits
//   fetch_entry_t - one queued {pc, instr} pair, as stored and as handed to decode
package fetch_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int INSTR_WIDTH = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular FIFO of {pc, instr} pairs between the fetch
// stage and decode. It uses valid/ready on both sides, and a flush empties it on
// a branch redirect. The head entry falls through combinationally from storage,
// so the decode stage sees a newly pushed entry one edge after the push.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (highest priority)
//   flush      in   synchronous discard of every entry; push/pop that cycle are dropped
//   in_valid   in   fetch presents an entry
//   in_ready   out  queue has room (depends only on registered occupancy)
//   in_pc      in   PC of the incoming instruction
//   in_instr   in   incoming instruction word
//   out_valid  out  head entry is valid
//   out_ready  in   decode accepts the head entry
//   out_pc     out  PC of the head entry, 0 when empty
//   out_instr  out  instruction of the head entry, 0 when empty
//   count      out  occupancy, 0..DEPTH
//
// DEPTH must be a power of two and at least 2, so that the pointers wrap
// naturally at PTR_W bits. The width parameters must match the fetch_pkg
// defaults, because storage uses fetch_entry_t.
module fetch_queue #(
    parameter int ADDR_WIDTH  = fetch_pkg::ADDR_WIDTH,
    parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
    parameter int DEPTH       = 4,
    parameter int PTR_W       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_WIDTH-1:0]  in_pc,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PTR_W:0]         count
);

    import fetch_pkg::*;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic             push_s;
    logic             pop_s;
    logic             write_en_s;
    logic [PTR_W-1:0] head_next_s;
    logic [PTR_W-1:0] tail_next_s;
    logic [PTR_W:0]   count_next_s;
    fetch_entry_t     in_entry_s;
    fetch_entry_t     head_entry_s;

    // Handshake qualification. Both flags come from registers, so in_ready never
    // depends on out_ready and a full queue refuses a push even while popping.
    always_comb begin
        push_s     = in_valid && in_ready_r;
        pop_s      = out_valid_r && out_ready;
        write_en_s = push_s && !flush && !reset;
        in_entry_s = '{pc: in_pc, instr: in_instr};
    end

    // Next pointer/occupancy. Flush overrides any push or pop in the same cycle.
    always_comb begin
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        count_next_s = count_r;
        if (flush) begin
            head_next_s  = '0;
            tail_next_s  = '0;
            count_next_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    tail_next_s  = tail_r + PTR_ONE;
                    count_next_s = count_r + COUNT_ONE;
                end
                2'b01: begin
                    head_next_s  = head_r + PTR_ONE;
                    count_next_s = count_r - COUNT_ONE;
                end
                2'b11: begin
                    // Simultaneous push and pop leave the occupancy unchanged.
                    head_next_s = head_r + PTR_ONE;
                    tail_next_s = tail_r + PTR_ONE;
                end
                default: begin
                    head_next_s  = head_r;
                    tail_next_s  = tail_r;
                    count_next_s = count_r;
                end
            endcase
        end
    end

    // Pointer and occupancy state. The ready/valid flags are registered
    // alongside count so that they always agree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            head_r      <= head_next_s;
            tail_r      <= tail_next_s;
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s != FULL_COUNT);
            out_valid_r <= (count_next_s != '0);
        end
    end

    // Entry storage. It is deliberately not reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            mem_r[tail_r] <= in_entry_s;
        end
    end

    // First-word fall-through read of the head. Outputs are zero when the queue is empty.
    always_comb begin
        if (out_valid_r) begin
            head_entry_s = mem_r[head_r];
        end else begin
            head_entry_s = '0;
        end
    end

    // Output assignments.
    always_comb begin
        in_ready  = in_ready_r;
        out_valid = out_valid_r;
        out_pc    = head_entry_s.pc;
        out_instr = head_entry_s.instr;
        count     = count_r;
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_pc = 12'h000;
    logic [31:0] in_instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;
    int mcount = 0;
    logic [43:0] sb[$];

    fetch_queue #(.ADDR_WIDTH(12), .INSTR_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .count(count)
    );

    always #5 clk = ~clk;

    // Drive one cycle from the negative edge. The bench model decides whether a
    // push/pop fires, and accepted pushes go on the scoreboard. popped tells the
    // caller that the head observed before the edge should match the front of sb.
    task automatic tick(input logic iv, input logic [11:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic rs,
                        output logic popped, output logic [11:0] opc, output logic [31:0] oins);
        logic push_ok;
        in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl; reset = rs;
        #1;
        opc = out_pc;
        oins = out_instr;
        push_ok = iv && (mcount != 4) && !fl && !rs;
        popped = (mcount != 0) && ordy && !fl && !rs;
        if (rs || fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (push_ok) begin
                sb.push_back({pc, ins});
                mcount++;
            end
            if (popped) mcount--;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        logic p; logic [11:0] opc; logic [31:0] oins;
        tick(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b1, p, opc, oins);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_pc !== 12'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=000", out_pc); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill_hold_head();
        logic p; logic [11:0] opc; logic [31:0] oins;
        logic [11:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{12'h000, 12'h004, 12'h008};
        ins = '{32'h00000013, 32'h00100093, 32'h00208113};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, pcs[i], ins[i], 1'b0, 1'b0, 1'b0, p, opc, oins);
            checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
            checks++; if (out_pc !== 12'h000 || out_instr !== 32'h00000013)
                begin failures++; $display("FAIL fill_head got=%h/%h exp=000/00000013", out_pc, out_instr); end
        end
    endtask

    task automatic test_full_backpressure();
        logic p; logic [11:0] opc; logic [31:0] oins; logic [43:0] exp;
        tick(1'b1, 12'h00C, 32'h00318193, 1'b0, 1'b0, 1'b0, p, opc, oins);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 12'h010, 32'h00420213, 1'b0, 1'b0, 1'b0, p, opc, oins);
            checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_hold_count got=%0d exp=4", count); end
        end
        // A pop while full still refuses the push in the same cycle.
        tick(1'b1, 12'h010, 32'h00420213, 1'b1, 1'b0, 1'b0, p, opc, oins);
        if (p) begin
            exp = sb.pop_front();
            checks++; if ({opc, oins} !== exp) begin failures++; $display("FAIL full_pop got=%h exp=%h", {opc, oins}, exp); end
        end
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_after_pop_count got=%0d exp=3", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop_ready got=%b exp=1", in_ready); end
        tick(1'b1, 12'h010, 32'h00420213, 1'b0, 1'b0, 1'b0, p, opc, oins);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_held_enter got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, p, opc, oins);
            if (p) begin
                exp = sb.pop_front();
                checks++; if ({opc, oins} !== exp) begin failures++; $display("FAIL full_drain got=%h exp=%h", {opc, oins}, exp); end
            end
        end
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL full_drained got=%b/%0d exp=0/0", out_valid, count); end
    endtask

    task automatic test_wrap_stream();
        logic p; logic [11:0] opc; logic [31:0] oins; logic [43:0] exp;
        int npops = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_start_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 11; i++) begin
            tick(i < 10, 12'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0, p, opc, oins);
            if (p) begin
                exp = sb.pop_front();
                npops++;
                checks++; if ({opc, oins} !== exp) begin failures++; $display("FAIL wrap_order got=%h exp=%h", {opc, oins}, exp); end
            end
            if (i < 10) begin
                checks++; if (count !== 3'd1) begin failures++; $display("FAIL wrap_steady_count got=%0d exp=1", count); end
            end
        end
        checks++; if (npops != 10 || count !== 3'd0) begin failures++; $display("FAIL wrap_pops got=%0d/%0d exp=10/0", npops, count); end
    endtask

    task automatic test_back_to_back();
        logic p; logic [11:0] opc; logic [31:0] oins; logic [43:0] exp;
        tick(1'b1, 12'h200, 32'h11111111, 1'b0, 1'b0, 1'b0, p, opc, oins);
        tick(1'b1, 12'h204, 32'h22222222, 1'b0, 1'b0, 1'b0, p, opc, oins);
        tick(1'b1, 12'h208, 32'h33333333, 1'b1, 1'b0, 1'b0, p, opc, oins);
        if (p) begin
            exp = sb.pop_front();
            checks++; if ({opc, oins} !== exp) begin failures++; $display("FAIL b2b_pop got=%h exp=%h", {opc, oins}, exp); end
        end
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", count); end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, p, opc, oins);
            if (p) begin
                exp = sb.pop_front();
                checks++; if ({opc, oins} !== exp) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", {opc, oins}, exp); end
            end
        end
    endtask

    task automatic test_flush();
        logic p; logic [11:0] opc; logic [31:0] oins; logic [43:0] exp;
        for (int i = 0; i < 3; i++) tick(1'b1, 12'h300 + 12'(i * 4), 32'hBEEF0000 + 32'(i), 1'b0, 1'b0, 1'b0, p, opc, oins);
        tick(1'b1, 12'h040, 32'h04040404, 1'b1, 1'b1, 1'b0, p, opc, oins);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0d/%b exp=0/0", count, out_valid); end
        checks++; if (out_pc !== 12'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_outputs got=%h/%b exp=000/1", out_pc, in_ready); end
        tick(1'b1, 12'h100, 32'h01000100, 1'b0, 1'b0, 1'b0, p, opc, oins);
        checks++; if (out_pc !== 12'h100 || out_instr !== 32'h01000100) begin failures++; $display("FAIL flush_new_head got=%h/%h exp=100/01000100", out_pc, out_instr); end
        tick(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, p, opc, oins);
        if (p) begin
            exp = sb.pop_front();
            checks++; if ({opc, oins} !== exp) begin failures++; $display("FAIL flush_drain got=%h exp=%h", {opc, oins}, exp); end
        end
    endtask

    task automatic test_reset_midstream();
        logic p; logic [11:0] opc; logic [31:0] oins; logic [43:0] exp;
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 12'h500, 32'h55555555, 1'b0, 1'b0, 1'b0, p, opc, oins);
            tick(1'b1, 12'h504, 32'h66666666, 1'b0, 1'b0, 1'b0, p, opc, oins);
            // k=0: reset alone; k=1: flush and reset together
            tick(1'b1, 12'h508, 32'h77777777, 1'b1, k == 1, 1'b1, p, opc, oins);
            checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_state k=%0d got=%0d/%b exp=0/0", k, count, out_valid); end
            checks++; if (out_instr !== 32'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_outputs k=%0d got=%h/%b exp=0/1", k, out_instr, in_ready); end
        end
        tick(1'b1, 12'h600, 32'h60006000, 1'b0, 1'b0, 1'b0, p, opc, oins);
        tick(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, p, opc, oins);
        if (p) begin
            exp = sb.pop_front();
            checks++; if ({opc, oins} !== exp) begin failures++; $display("FAIL rst_mid_after got=%h exp=%h", {opc, oins}, exp); end
        end
    endtask

    task automatic test_random();
        logic p; logic [11:0] opc; logic [31:0] oins; logic [43:0] exp;
        logic iv, ordy, fl;
        for (int i = 0; i < 300; i++) begin
            iv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 39) == 0);
            tick(iv, 12'($urandom), $urandom, ordy, fl, 1'b0, p, opc, oins);
            if (p) begin
                exp = sb.pop_front();
                checks++; if ({opc, oins} !== exp) begin failures++; $display("FAIL rand_pop i=%0d got=%h exp=%h", i, {opc, oins}, exp); end
            end
            checks++; if (count !== 3'(mcount) || in_ready !== (mcount != 4) || out_valid !== (mcount != 0))
                begin failures++; $display("FAIL rand_state i=%0d got=%0d/%b/%b exp=%0d", i, count, in_ready, out_valid, mcount); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_hold_head();
        test_full_backpressure();
        test_wrap_stream();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_queue
